pq_expiry_dispatch: RTL
=======================

Name: pq_expiry_dispatch

Overview:
Downstream consumer of the hardware priority queue. Keeps the free-running system timestamp and watches the queue head cell, whose data field holds a deadline and id field an entry tag. Once the head deadline is reached, it pops the head from the queue and presents {id, lateness} as an event on a valid/ready output. Sits between the priority queue and the event/interrupt fabric.

Parameters:
TIME_WIDTH, pq_pkg::TIME_WIDTH, width of timestamps and deadlines.
ID_WIDTH, pq_pkg::ID_WIDTH, width of entry tags.
PRESCALE, 1, clk_i cycles per timestamp tick (>=1).
POP_LAT, 2, cycles the queue needs after a pop before head_valid_i/head_i are valid again (>=1).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  1 = dispatch allowed; the timestamp runs regardless
head_valid_i  in  1  queue head present (queue non-empty)
head_i  in  pq_pkg::cell_t  head cell: data = deadline, id = tag
pop_o  out  1  single-cycle pop request to the queue
time_o  out  TIME_WIDTH  current timestamp
evt_valid_o  out  1  event available
evt_ready_i  in  1  consumer accepts event
evt_id_o  out  ID_WIDTH  tag of the expired entry
evt_late_o  out  TIME_WIDTH  time_o minus deadline, sampled at pop
busy_o  out  1  state != IDLE or evt_valid_o

Behaviour:
- Reset: time_o=0, prescaler=0, pop_o=0, evt_valid_o=0, evt_id_o=0, evt_late_o=0, state=IDLE. Reset applied mid-operation drops any held event and any settle count. The queue is not popped again.
- Timestamp: prescaler counts 0..PRESCALE-1. time_o increments by 1 in the cycle after the prescaler reaches PRESCALE-1 and wraps modulo 2^TIME_WIDTH. With PRESCALE=1, time_o increments every cycle.
- Expiry: diff = time_o - head_i.data, modulo 2^TIME_WIDTH. expired = head_valid_i && (diff[TIME_WIDTH-1]==0). This is a wrap-safe compare, valid while deadlines stay within 2^(TIME_WIDTH-1) ticks of now. diff==0 counts as expired.
- Output slot: a single register. It is free when evt_valid_o==0, or when evt_valid_o && evt_ready_i in the same cycle (pass-through refill allowed).
- FSM:
  - IDLE: if enable_i && expired && slot free, then assert pop_o for this cycle. In the same edge, latch evt_id_o=head_i.id and evt_late_o=diff, set evt_valid_o=1, load the settle counter with POP_LAT-1, and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: pop_o=0. Decrement the counter. When the counter reaches 0, go to IDLE. Head inputs are ignored in this state.
- Throughput: at most one pop per POP_LAT+1 cycles.
- Latency: pop_o and evt_valid_o both rise in the cycle after the head becomes expired. Combinational pop_o is permitted only if it is registered-equivalent: pop_o is a registered pulse, and event fields register in the same edge.
- evt_*: the event holds stable while evt_valid_o && !evt_ready_i. evt_valid_o clears on handshake unless it is refilled in the same cycle.
- enable_i deasserted: no new pops. Any SETTLE in progress completes, and a held event still drains.
- Head changes while IDLE (a new earlier deadline is pushed) are used as soon as they appear. No caching.
- head_valid_i==0: never pops, whatever the value of head_i.
- Backpressure: when the slot is full and evt_ready_i==0, expired entries stay in the queue. No loss and no duplication.

Decomposition:
- pq_pkg gains:
  - typedef pq_evt_t {id, late}
  - function time_reached(now, deadline), the wrap-safe compare, shared with the queue's insert logic.
- Uses the existing cell_t and ID_WIDTH.
- One natural sub-module: pq_timebase (prescaler plus timestamp counter). FSM and output register stay inline.

Test Plan:
1. Reset with PRESCALE=1: time_o counts 0,1,2… every cycle. pop_o=0 and evt_valid_o=0 throughout with head_valid_i=0.
2. head deadline=10, id=3, evt_ready_i=1: pop_o is a one-cycle pulse in the cycle after time_o reaches 10. The event shows id=3, late=0. No second pop during the POP_LAT=2 settle cycles.
3. Hold evt_ready_i=0 with two expired entries (ids 1, 2): exactly one pop, and id=1 is held stable. After ready rises, id=2 pops within 1 cycle of the slot freeing. Total pops = 2.
4. Wrap-around, TIME_WIDTH=8, time_o=250, deadline=4: expires at time_o=4 (late=0), not at 250.
5. Head deadline=5 while time_o=20: immediate pop with late=15. With enable_i=0, no pop occurs until enable_i rises.
6. Assert rst_i during SETTLE with an event pending: next cycle evt_valid_o=0, time_o=0, state=IDLE, no extra pop_o.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared priority-queue types: queue cell, dispatch event, and the wrap-safe
// deadline compare used by both the queue insert path and the expiry dispatcher.
package pq_pkg;
    localparam int TIME_WIDTH = 8;
    localparam int ID_WIDTH   = 4;

    typedef struct packed {
        logic [TIME_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } cell_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [TIME_WIDTH-1:0] late;
    } pq_evt_t;

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } disp_state_t;

    // True once now has reached deadline; valid while the two stay within half the timestamp range.
    function automatic logic time_reached(input logic [TIME_WIDTH-1:0] now,
                                          input logic [TIME_WIDTH-1:0] deadline);
        logic [TIME_WIDTH-1:0] diff;
        diff = now - deadline;
        return ~diff[TIME_WIDTH-1];
    endfunction
endpackage

// File: rtl/pq_expiry_dispatch_if.sv
// Queue-head / pop handshake plus the valid/ready event output of the expiry dispatcher.
interface pq_expiry_dispatch_if;
    import pq_pkg::*;

    logic                  head_valid_i;
    cell_t                 head_i;
    logic                  pop_o;
    logic                  evt_valid_o;
    logic                  evt_ready_i;
    logic [ID_WIDTH-1:0]   evt_id_o;
    logic [TIME_WIDTH-1:0] evt_late_o;

    modport master (
        input  head_valid_i, head_i, evt_ready_i,
        output pop_o, evt_valid_o, evt_id_o, evt_late_o
    );

    modport slave (
        output head_valid_i, head_i, evt_ready_i,
        input  pop_o, evt_valid_o, evt_id_o, evt_late_o
    );
endinterface

// File: rtl/pq_timebase.sv
// Free-running timestamp: advances once every PRESCALE clocks, wrapping modulo 2^TIME_WIDTH.
module pq_timebase #(
    parameter int TIME_WIDTH = pq_pkg::TIME_WIDTH,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [TIME_WIDTH-1:0] time_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre    <= '0;
            time_o <= '0;
        end else if (tick) begin
            pre    <= '0;
            time_o <= time_o + TIME_WIDTH'(1);
        end else begin
            pre    <= pre + PW'(1);
        end
    end
endmodule

// File: rtl/pq_expiry_dispatch.sv
// Pops the queue head once its deadline is reached and presents {id, lateness}
// as a single-slot valid/ready event; waits POP_LAT cycles for the head to settle.
module pq_expiry_dispatch
    import pq_pkg::*;
#(
    parameter int TIME_WIDTH = pq_pkg::TIME_WIDTH,
    parameter int ID_WIDTH   = pq_pkg::ID_WIDTH,
    parameter int PRESCALE   = 1,
    parameter int POP_LAT    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    pq_expiry_dispatch_if.master     bus,
    output logic [TIME_WIDTH-1:0]    time_o,
    output logic                     busy_o
);
    localparam int CW = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

    disp_state_t           state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [TIME_WIDTH-1:0] diff;
    logic                  expired, slot_free, fire;
    logic                  pop_q, evt_valid;
    pq_evt_t               evt;

    pq_timebase #(
        .TIME_WIDTH (TIME_WIDTH),
        .PRESCALE   (PRESCALE)
    ) u_timebase (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .time_o (time_o)
    );

    assign diff      = time_o - bus.head_i.data;
    assign expired   = bus.head_valid_i && time_reached(time_o, bus.head_i.data);
    // A held event being accepted this cycle frees the slot for an immediate refill.
    assign slot_free = !evt_valid || bus.evt_ready_i;
    assign fire      = (state == ST_IDLE) && enable_i && expired && slot_free;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (fire) begin
                    state_n = ST_SETTLE;
                    cnt_n   = CW'(POP_LAT - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pop_q     <= 1'b0;
            evt_valid <= 1'b0;
            evt       <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pop_q <= fire;
            if (fire) begin
                evt_valid <= 1'b1;
                evt.id    <= bus.head_i.id;
                evt.late  <= diff;
            end else if (bus.evt_ready_i) begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign bus.pop_o       = pop_q;
    assign bus.evt_valid_o = evt_valid;
    assign bus.evt_id_o    = evt.id;
    assign bus.evt_late_o  = evt.late;
    assign busy_o          = (state != ST_IDLE) || evt_valid;
endmodule
